// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and stall controller for a classic 5-stage in-order pipeline.
// Resolves, in priority order: data-memory wait stalls, taken-branch flushes,
// and load-use bubbles. A memory access that never completes is abandoned
// after TIMEOUT wait cycles, and a sticky error flag is raised.
//
// Ports
//   clk          : clock, all state on rising edge
//   rst          : synchronous reset, active low
//   id_rs/id_rt  : source registers of the instruction in ID
//   ex_memread   : instruction in EX is a load
//   ex_rt        : destination register of the load in EX
//   ex_br_taken  : branch/jump in EX resolved taken
//   mem_req      : MEM-stage instruction is accessing data memory
//   mem_ready    : data memory completes the access this cycle
//   pc_write     : PC update enable
//   ifid_write   : IF/ID write enable
//   ifid_flush   : IF/ID clear (dominates ifid_write)
//   idex_flush   : bubble into ID/EX
//   exmem_write  : EX/MEM and MEM/WB advance enable
//   mem_err      : sticky memory-timeout flag
//   stall_cnt    : saturating count of cycles with pc_write low
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MEMWAIT = 1'b1;
  localparam logic [7:0] TO      = 8'(TIMEOUT);

  logic [0:0]       r_state;
  logic [7:0]       r_wcnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ms;
  logic w_lu;
  logic w_freeze;

  assign w_ms = mem_req & ~mem_ready & ~r_mem_err;
  assign w_lu = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // In MEMWAIT the pipeline stays frozen until the memory answers; the
  // timeout cycle itself is also frozen, the release happens one cycle later.
  assign w_freeze = (r_state == RUN) ? w_ms : ~mem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (ex_br_taken) begin
      // Taken branch squashes the younger instructions; any load-use
      // hazard against the squashed ID instruction is moot.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_lu) begin
      // Hold IF and ID one cycle and let the load move on to MEM.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wcnt      <= 8'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!pc_write && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      case (r_state)
        RUN: begin
          if (w_ms) begin
            r_state <= MEMWAIT;
            r_wcnt  <= 8'd1;
          end
        end
        default: begin
          if (mem_ready) begin
            r_state <= RUN;
            r_wcnt  <= 8'd0;
          end else if (r_wcnt >= TO) begin
            r_state   <= RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic       ex_memread = 1'b0, ex_br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, mem_err;
  logic [15:0] stall_cnt;
  logic        d2_pc_write, d2_ifid_write, d2_ifid_flush, d2_idex_flush, d2_exmem_write, d2_mem_err;
  logic [2:0]  d2_stall_cnt;

  logic [4:0] ctl;
  assign ctl = {pc_write, ifid_write, exmem_write, ifid_flush, idex_flush};

  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_NRM = 5'b11100;
  localparam logic [4:0] C_BR  = 5'b11111;
  localparam logic [4:0] C_LU  = 5'b00101;
  localparam logic [4:0] C_RST = 5'b00011;

  int checks = 0;
  int passed = 0;
  int exp_sc = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_write(exmem_write), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(d2_pc_write), .ifid_write(d2_ifid_write), .ifid_flush(d2_ifid_flush),
    .idex_flush(d2_idex_flush), .exmem_write(d2_exmem_write), .mem_err(d2_mem_err),
    .stall_cnt(d2_stall_cnt)
  );

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mrd,
                        input logic [4:0] ert, input logic br, input logic mq, input logic mr);
    id_rs = rs; id_rt = rt; ex_memread = mrd; ex_rt = ert;
    ex_br_taken = br; mem_req = mq; mem_ready = mr;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== C_RST) $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b expected 0", mem_err);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NRM) $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_NRM);
    else passed++;
    @(posedge clk); #1;
    exp_sc = 0;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_release_cnt: got %0d expected 0", stall_cnt);
    else passed++;
  endtask

  task automatic test_load_use();
    logic [4:0] rs_v [3] = '{5'd5, 5'd1, 5'd6};
    logic [4:0] rt_v [3] = '{5'd2, 5'd7, 5'd8};
    logic [4:0] ert_v[3] = '{5'd5, 5'd7, 5'd7};
    logic [4:0] exp_v[3] = '{C_LU, C_LU, C_NRM};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(rs_v[i], rt_v[i], 1'b1, ert_v[i], 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (ctl !== exp_v[i]) $display("FAIL load_use_ctl[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      else passed++;
      if (exp_v[i][4] == 1'b0) exp_sc++;
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 16'(exp_sc)) $display("FAIL load_use_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_sc);
      else passed++;
    end
  endtask

  task automatic test_rt_zero();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NRM) $display("FAIL rt_zero_ctl: got %b expected %b", ctl, C_NRM);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'(exp_sc)) $display("FAIL rt_zero_cnt: got %0d expected %0d", stall_cnt, exp_sc);
    else passed++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_in(5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_BR) $display("FAIL branch_ctl: got %b expected %b", ctl, C_BR);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'(exp_sc)) $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_sc);
    else passed++;
  endtask

  task automatic test_mem_same_cycle();
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (ctl !== C_NRM) $display("FAIL mem_same_ctl: got %b expected %b", ctl, C_NRM);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NRM) $display("FAIL mem_same_after: got %b expected %b", ctl, C_NRM);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_wait();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, (i == 3));
      #1;
      e = (i < 3) ? C_FRZ : C_NRM;
      checks++;
      if (ctl !== e) $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, ctl, e);
      else passed++;
      if (i < 3) exp_sc++;
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 16'(exp_sc)) $display("FAIL mem_wait_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_sc);
      else passed++;
    end
    checks++;
    if (mem_err !== 1'b0) $display("FAIL mem_wait_err: got %b expected 0", mem_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // load-use, branch+load-use, memory stall, release-with-load-use, idle
    logic       mrd_v[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       br_v [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       mq_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       mr_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_v[5] = '{C_LU, C_BR, C_FRZ, C_LU, C_NRM};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(5'd4, 5'd11, mrd_v[i], 5'd11, br_v[i], mq_v[i], mr_v[i]);
      #1;
      checks++;
      if (ctl !== exp_v[i]) $display("FAIL b2b_ctl[%0d]: got %b expected %b", i, ctl, exp_v[i]);
      else passed++;
      if (exp_v[i][4] == 1'b0) exp_sc++;
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== 16'(exp_sc)) $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_sc);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (ctl !== C_FRZ) $display("FAIL timeout_ctl[%0d]: got %b expected %b", i, ctl, C_FRZ);
      else passed++;
      exp_sc++;
      @(posedge clk); #1;
      checks++;
      if (mem_err !== (i == 4)) $display("FAIL timeout_err[%0d]: got %b expected %b", i, mem_err, (i == 4));
      else passed++;
    end
    checks++;
    if (stall_cnt !== 16'(exp_sc)) $display("FAIL timeout_cnt: got %0d expected %0d", stall_cnt, exp_sc);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (ctl !== C_NRM) $display("FAIL timeout_after_ctl[%0d]: got %b expected %b", i, ctl, C_NRM);
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (mem_err !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", mem_err);
    else passed++;
  endtask

  task automatic test_reset_in_memwait();
    @(negedge clk);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_sc = 0;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL rst_mw_clear_err: got %b expected 0", mem_err);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (ctl !== C_FRZ) $display("FAIL rst_mw_frz[%0d]: got %b expected %b", i, ctl, C_FRZ);
      else passed++;
      exp_sc++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 16'(exp_sc)) $display("FAIL rst_mw_pre_cnt: got %0d expected %0d", stall_cnt, exp_sc);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RST) $display("FAIL rst_mw_ctl: got %b expected %b", ctl, C_RST);
    else passed++;
    @(posedge clk); #1;
    exp_sc = 0;
    @(negedge clk);
    rst = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NRM) $display("FAIL rst_mw_run: got %b expected %b", ctl, C_NRM);
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL rst_mw_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL rst_mw_err: got %b expected 0", mem_err);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b1;
      set_in(5'd12, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      exp_sc++;
    end
    checks++;
    if (stall_cnt !== 16'(exp_sc)) $display("FAIL sat_wide_cnt: got %0d expected %0d", stall_cnt, exp_sc);
    else passed++;
    checks++;
    if (d2_stall_cnt !== 3'd7) $display("FAIL sat_narrow_cnt: got %0d expected 7", d2_stall_cnt);
    else passed++;
    @(negedge clk);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch();
    test_mem_same_cycle();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_in_memwait();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
